axi_slave_mem_param: RTL

Parametrised AXI4 slave memory, the next generation of our fixed-width axi_dut. It adds configurable data, ID and depth widths, FIXED/INCR/WRAP bursts, byte strobes, and SLVERR on bad address, bad WRAP length or wlast mismatch. It sits behind the AXI interface as the DUT memory target.

---
 rtl/axi_slave_mem_param.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_mem_param.sv
// AXI4 slave memory: parametrised width/depth, FIXED/INCR/WRAP bursts, byte strobes, SLVERR reporting.
// Read data is registered (1-cycle AR-to-R latency); independent read and write channels.
module axi_slave_mem_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] RESP_OK = 2'b00;
    localparam logic [1:0] RESP_SE = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BYTES - 1);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> (OFF_W + IDX_W)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    // Illegal bursts fall back to INCR stepping; WRAP keeps the upper bits of the aligned block.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                    input logic [1:0] burst, input logic bad);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = a + ADDR_W'(BYTES);
        mask = (({{(ADDR_W-8){1'b0}}, len} + ADDR_W'(1)) << OFF_W) - ADDR_W'(1);
        if (bad || burst == B_INCR) return inc;
        if (burst == B_FIXED)       return a;
        return (a & ~mask) | (inc & mask);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    wstate_t           wstate_q, wstate_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d, wburst_q, wburst_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic              wbad_q, wbad_d, werr_q, werr_d, mem_we, w_beat_err;

    always_comb begin
        wstate_d   = wstate_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        wa_d       = wa_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wbad_d     = wbad_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        mem_we     = 1'b0;
        w_beat_err = 1'b0;
        case (wstate_q)
            W_IDLE: if (s_axi_awvalid && awready_q) begin
                wstate_d = W_DATA;
                bid_d    = s_axi_awid;
                wa_d     = align(s_axi_awaddr);
                wlen_d   = s_axi_awlen;
                wburst_d = s_axi_awburst;
                wbad_d   = burst_bad(s_axi_awburst, s_axi_awlen);
                wcnt_d   = '0;
                werr_d   = 1'b0;
            end
            W_DATA: if (s_axi_wvalid && wready_q) begin
                mem_we     = in_range(wa_q);
                w_beat_err = !in_range(wa_q) || wbad_q || (s_axi_wlast != (wcnt_q == wlen_q));
                werr_d     = werr_q || w_beat_err;
                wa_d       = next_addr(wa_q, wlen_q, wburst_q, wbad_q);
                wcnt_d     = wcnt_q + 8'd1;
                if (wcnt_q == wlen_q) begin
                    wstate_d = W_RESP;
                    bresp_d  = werr_d ? RESP_SE : RESP_OK;
                end
            end
            W_RESP: if (bvalid_q && s_axi_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
        bvalid_d  = (wstate_d == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            wa_q      <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wbad_q    <= 1'b0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            wa_q      <= wa_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wbad_q    <= wbad_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
        end
    end

    // Contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb[b]) mem_q[widx(wa_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    rstate_t           rstate_q, rstate_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d, rburst_q, rburst_d;
    logic [ADDR_W-1:0] ra_q, ra_d, rd_addr;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic              rbad_q, rbad_d, rd_load, rd_bad;

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        ra_d     = ra_q;
        rlen_d   = rlen_q;
        rburst_d = rburst_q;
        rbad_d   = rbad_q;
        rcnt_d   = rcnt_q;
        rd_load  = 1'b0;
        rd_addr  = ra_q;
        rd_bad   = rbad_q;
        case (rstate_q)
            R_IDLE: if (s_axi_arvalid && arready_q) begin
                rstate_d = R_DATA;
                rid_d    = s_axi_arid;
                rlen_d   = s_axi_arlen;
                rburst_d = s_axi_arburst;
                rbad_d   = burst_bad(s_axi_arburst, s_axi_arlen);
                rcnt_d   = '0;
                rd_addr  = align(s_axi_araddr);
                rd_bad   = rbad_d;
                rd_load  = 1'b1;
            end
            R_DATA: if (rvalid_q && s_axi_rready) begin
                if (rlast_q) begin
                    rstate_d = R_IDLE;
                    rlast_d  = 1'b0;
                end else begin
                    rd_addr = next_addr(ra_q, rlen_q, rburst_q, rbad_q);
                    rcnt_d  = rcnt_q + 8'd1;
                    rd_load = 1'b1;
                end
            end
        endcase
        // Next beat is fetched only on a handshake, so R outputs hold while stalled.
        if (rd_load) begin
            ra_d    = rd_addr;
            rdata_d = in_range(rd_addr) ? mem_q[widx(rd_addr)] : '0;
            rresp_d = (rd_bad || !in_range(rd_addr)) ? RESP_SE : RESP_OK;
            rlast_d = (rcnt_d == rlen_d);
        end
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ra_q      <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ra_q      <= ra_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
endmodule
